// File: rtl/float_div_iter.sv
// Multi-cycle restoring float divider S = A / B, one quotient bit per clock, valid/ready in, done pulse out.
// Optional FDIV_ROUND_NEAREST_EN selects round-to-nearest-even; otherwise the quotient is truncated.
module float_div_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   S,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   ERR
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(MAN_W + 3);
  localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0] LAST = CW'(MAN_W + 1);
  localparam logic [W-1:0]  QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, PACK} state_t;
  state_t r_state;

  logic [MAN_W+1:0] r_rem;
  logic [MAN_W:0]   r_mb;
  logic [MAN_W:0]   r_q;
  logic [EW-1:0]    r_e;
  logic [CW-1:0]    r_cnt;
  logic             r_sign;
  logic             r_spec;
  logic             r_spec_err;
  logic [W-1:0]     r_spec_s;

  // operand decode
  logic             w_sa, w_sb, w_sign;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

  assign w_sa     = A[W-1];
  assign w_sb     = B[W-1];
  assign w_ea     = A[W-2:MAN_W];
  assign w_eb     = B[W-2:MAN_W];
  assign w_fa     = A[MAN_W-1:0];
  assign w_fb     = B[MAN_W-1:0];
  assign w_sign   = w_sa ^ w_sb;
  assign w_a_nan  = (&w_ea) & (|w_fa);
  assign w_b_nan  = (&w_eb) & (|w_fb);
  assign w_a_inf  = (&w_ea) & ~(|w_fa);
  assign w_b_inf  = (&w_eb) & ~(|w_fb);
  assign w_a_zero = ~(|w_ea);
  assign w_b_zero = ~(|w_eb);

  logic         w_spec, w_spec_err;
  logic [W-1:0] w_spec_s;

  always_comb begin
    w_spec     = 1'b1;
    w_spec_err = 1'b0;
    w_spec_s   = {w_sign, {(EXP_W+MAN_W){1'b0}}};
    if (w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf)) begin
      w_spec_s   = QNAN;
      w_spec_err = 1'b1;
    end else if (w_b_zero & ~w_a_inf) begin
      w_spec_s   = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_spec_err = 1'b1;
    end else if (w_a_inf) begin
      w_spec_s   = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (w_a_zero | w_b_inf) begin
      w_spec_s   = {w_sign, {(EXP_W+MAN_W){1'b0}}};
    end else begin
      w_spec     = 1'b0;
    end
  end

  // pre-normalise so the quotient lands in [1,2)
  logic [MAN_W:0]   w_ma, w_mb;
  logic             w_lt;
  logic [EW-1:0]    w_e0;
  logic [MAN_W+1:0] w_rem0;

  assign w_ma   = {1'b1, w_fa};
  assign w_mb   = {1'b1, w_fb};
  assign w_lt   = w_ma < w_mb;
  assign w_e0   = {2'b00, w_ea} - {2'b00, w_eb} + BIAS - EW'(w_lt);
  assign w_rem0 = w_lt ? {w_ma, 1'b0} : {1'b0, w_ma};

  logic             w_ge;
  logic [MAN_W+1:0] w_diff, w_rem_sel;

  assign w_ge      = r_rem >= {1'b0, r_mb};
  assign w_diff    = r_rem - {1'b0, r_mb};
  assign w_rem_sel = w_ge ? w_diff : r_rem;

  // r_q holds {frac, guard}; the hidden bit has shifted out by PACK
  logic [MAN_W-1:0] w_frac;
  logic             w_guard, w_sticky, w_rnd;
  logic [MAN_W:0]   w_mant;
  logic [EW-1:0]    w_ef;
  logic             w_ovf, w_unf;

  assign w_frac   = r_q[MAN_W:1];
  assign w_guard  = r_q[0];
  assign w_sticky = |r_rem;
`ifdef FDIV_ROUND_NEAREST_EN
  assign w_rnd    = w_guard & (w_sticky | w_frac[0]);
`else
  assign w_rnd    = 1'b0 & w_guard & w_sticky;
`endif
  assign w_mant   = {1'b0, w_frac} + (MAN_W+1)'(w_rnd);
  assign w_ef     = r_e + EW'(w_mant[MAN_W]);
  assign w_ovf    = $signed(w_ef) >= $signed(EMAX);
  assign w_unf    = w_ef[EW-1] | (w_ef == '0);

  assign in_ready = (r_state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      done      <= 1'b0;
      S         <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: if (in_valid) begin
          r_sign     <= w_sign;
          r_spec     <= w_spec;
          r_spec_err <= w_spec_err;
          r_spec_s   <= w_spec_s;
          r_mb       <= w_mb;
          r_rem      <= w_rem0;
          r_e        <= w_e0;
          r_q        <= '0;
          r_cnt      <= '0;
          r_state    <= w_spec ? PACK : CALC;
        end
        CALC: begin
          r_q   <= {r_q[MAN_W-1:0], w_ge};
          r_rem <= w_rem_sel << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= PACK;
        end
        PACK: begin
          done    <= 1'b1;
          r_state <= IDLE;
          if (r_spec) begin
            S         <= r_spec_s;
            ERR       <= r_spec_err;
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end else begin
            ERR       <= 1'b0;
            overflow  <= w_ovf;
            underflow <= ~w_ovf & w_unf;
            if (w_ovf)      S <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else if (w_unf) S <= {r_sign, {(EXP_W+MAN_W){1'b0}}};
            else            S <= {r_sign, w_ef[EXP_W-1:0], w_mant[MAN_W-1:0]};
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_float_div_iter.sv
// Directed vector table plus reset-abort and continuous-valid sequences for float_div_iter.
module tb_float_div_iter;
  logic        clk = 1'b0;
  logic        rst_n, in_valid;
  logic        in_ready, done, overflow, underflow, ERR;
  logic [31:0] A, B, S;

  float_div_iter #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .done(done), .S(S),
    .overflow(overflow), .underflow(underflow), .ERR(ERR)
  );

  always #5 clk = ~clk;

`ifdef FDIV_ROUND_NEAREST_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
  localparam logic [31:0] TWO3  = 32'h3F2AAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
  localparam logic [31:0] TWO3  = 32'h3F2AAAAA;
`endif

  typedef struct {
    logic [31:0] a, b, s;
    logic        ovf, unf, err;
    int          lat;
  } vec_t;

  vec_t vt[$];
  int   n_chk = 0, n_pass = 0;

  task automatic add(input logic [31:0] a, b, s, input logic ovf, unf, err, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.ovf = ovf; v.unf = unf; v.err = err; v.lat = lat;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // accept on the next edge, then count edges until done
  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    lat = 0;
    A = v.a; B = v.b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(posedge clk); #1;
      if (done) lat = c;
    end
    chk($sformatf("v%0d_lat", idx), 32'(lat), 32'(v.lat));
    chk($sformatf("v%0d_S", idx), S, v.s);
    chk($sformatf("v%0d_ovf", idx), {31'b0, overflow}, {31'b0, v.ovf});
    chk($sformatf("v%0d_unf", idx), {31'b0, underflow}, {31'b0, v.unf});
    chk($sformatf("v%0d_err", idx), {31'b0, ERR}, {31'b0, v.err});
    @(posedge clk); #1;
    chk($sformatf("v%0d_pulse", idx), {31'b0, done}, 32'd0);
  endtask

  logic [31:0] pa[3], pb[3], ps[3];
  int          pl[3];

  initial begin
    int          cnt, n_acc, n_done, ndone_rst;
    logic        acc, exp_done;
    logic [31:0] exp_s;

    add(32'h40C00000, 32'h40000000, 32'h40400000, 0, 0, 0, 26);
    add(32'hC0C00000, 32'h40000000, 32'hC0400000, 0, 0, 0, 26);
    add(32'h3F800000, 32'h40400000, THIRD,        0, 0, 0, 26);
    add(32'h40000000, 32'h40400000, TWO3,         0, 0, 0, 26);
    add(32'h3FC00000, 32'h3F800000, 32'h3FC00000, 0, 0, 0, 26);
    add(32'h3F800000, 32'h3F800000, 32'h3F800000, 0, 0, 0, 26);
    add(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 0, 0, 0, 26);
    add(32'h7F000000, 32'h3E800000, 32'h7F800000, 1, 0, 0, 26);
    add(32'h7F000000, 32'h3F000000, 32'h7F800000, 1, 0, 0, 26);
    add(32'h00800000, 32'h40000000, 32'h00000000, 0, 1, 0, 26);
    add(32'h01000000, 32'h40000000, 32'h00800000, 0, 0, 0, 26);
    add(32'h3F800000, 32'h00000000, 32'h7F800000, 0, 0, 1, 1);
    add(32'hBF800000, 32'h80000000, 32'h7F800000, 0, 0, 1, 1);
    add(32'h00000000, 32'h00000000, 32'h7FC00000, 0, 0, 1, 1);
    add(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 0, 0, 1, 1);
    add(32'h3F800000, 32'h7FC00001, 32'h7FC00000, 0, 0, 1, 1);
    add(32'h7F800000, 32'h7F800000, 32'h7FC00000, 0, 0, 1, 1);
    add(32'h7F800000, 32'h00000000, 32'h7F800000, 0, 0, 0, 1);
    add(32'hFF800000, 32'h3F800000, 32'hFF800000, 0, 0, 0, 1);
    add(32'h00000000, 32'hBF800000, 32'h80000000, 0, 0, 0, 1);
    add(32'h3F800000, 32'h7F800000, 32'h00000000, 0, 0, 0, 1);
    add(32'h00400000, 32'h3F800000, 32'h00000000, 0, 0, 0, 1);
    add(32'h3F800000, 32'h00400000, 32'h7F800000, 0, 0, 1, 1);

    pa[0] = 32'h40C00000; pb[0] = 32'h40000000; ps[0] = 32'h40400000; pl[0] = 26;
    pa[1] = 32'h3F800000; pb[1] = 32'h00000000; ps[1] = 32'h7F800000; pl[1] = 1;
    pa[2] = 32'h3FC00000; pb[2] = 32'h3F800000; ps[2] = 32'h3FC00000; pl[2] = 26;

    rst_n = 1'b0; in_valid = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_done",  {31'b0, done}, 32'd0);
    chk("rst_S",     S, 32'd0);
    chk("rst_flags", {29'b0, overflow, underflow, ERR}, 32'd0);

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], i);

    // reset asserted at edge 10 of a divide
    A = 32'h40C00000; B = 32'h40000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_ready", {31'b0, in_ready}, 32'd1);
    chk("abort_done",  {31'b0, done}, 32'd0);
    chk("abort_S",     S, 32'd0);
    chk("abort_flags", {29'b0, overflow, underflow, ERR}, 32'd0);
    ndone_rst = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) ndone_rst++;
    end
    chk("abort_nodone", 32'(ndone_rst), 32'd0);
    run_vec(vt[2], 100);

    // in_valid held high with changing operands; model tracks busy time
    cnt = 0; n_acc = 0; n_done = 0; exp_s = '0;
    for (int i = 0; i < 110; i++) begin
      in_valid = (i < 80);
      A = pa[i % 3]; B = pb[i % 3];
      chk("cont_ready", {31'b0, in_ready}, {31'b0, cnt == 0});
      acc = (cnt == 0) && in_valid;
      @(posedge clk); #1;
      exp_done = 1'b0;
      if (acc) begin
        cnt = pl[i % 3]; exp_s = ps[i % 3]; n_acc++;
      end else if (cnt > 0) begin
        cnt--;
        exp_done = (cnt == 0);
      end
      if (done) n_done++;
      chk("cont_done", {31'b0, done}, {31'b0, exp_done});
      if (exp_done) chk("cont_S", S, exp_s);
    end
    in_valid = 1'b0;
    chk("cont_count", 32'(n_done), 32'(n_acc));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
